// File: rtl/spec_pkg.sv
// rtl/spec_pkg.sv - shared constants and FSM state type for the spectrum modulus RAM reader
`timescale 1ns/1ps
package spec_pkg;

    localparam int SPEC_ADDR_W    = 12;
    localparam int SPEC_DATA_W    = 24;
    localparam int SPEC_BIN_COUNT = 2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } spec_state_t;

endpackage

// File: rtl/spec_reader_if.sv
// rtl/spec_reader_if.sv - bin stream from the modulus reader to its consumer
`timescale 1ns/1ps
interface spec_reader_if #(
    parameter int ADDR_W = spec_pkg::SPEC_ADDR_W,
    parameter int DATA_W = spec_pkg::SPEC_DATA_W
) ();

    logic [DATA_W-1:0] m_tdata;
    logic [ADDR_W-1:0] m_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    modport master (
        output m_tdata,
        output m_tuser,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tuser,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );

endinterface

// File: rtl/spec_skid_fifo.sv
// rtl/spec_skid_fifo.sv - small synchronous FIFO with occupancy count and flush
`timescale 1ns/1ps
module spec_skid_fifo #(
    parameter  int WIDTH = 37,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/spec_reader.sv
// rtl/spec_reader.sv - streams learned modulus bins from RAM port B with backpressure-safe credits
// Optional peak-bin tracking is built when SPEC_READER_PEAK_EN is defined.
`timescale 1ns/1ps
module spec_reader import spec_pkg::*; #(
    parameter int ADDR_W    = SPEC_ADDR_W,
    parameter int DATA_W    = SPEC_DATA_W,
    parameter int BIN_START = 0,
    parameter int BIN_COUNT = SPEC_BIN_COUNT,
    parameter int RD_LAT    = 2
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              learn_done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    spec_reader_if.master     m_if,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [DATA_W-1:0] peak_val
);

    localparam int DEPTH  = RD_LAT + 2;
    localparam int FW     = DATA_W + ADDR_W + 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ICNT_W = ADDR_W + 1;
    localparam int IFL_W  = $clog2(RD_LAT + 1);

    localparam logic [ADDR_W-1:0] FIRST_BIN  = ADDR_W'(BIN_START);
    localparam logic [ADDR_W-1:0] LAST_BIN   = ADDR_W'(BIN_START + BIN_COUNT - 1);
    localparam logic [ICNT_W-1:0] LAST_ISSUE = ICNT_W'(BIN_COUNT - 1);

    spec_state_t       state_q, state_d;
    logic [ICNT_W-1:0] icnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] idx_q [RD_LAT];

    logic              accept;
    logic              issue;
    logic              abort_act;
    logic              credit;
    logic [IFL_W-1:0]  in_flight;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_din;
    logic [FW-1:0]     fifo_dout;
    logic [CNT_W-1:0]  fifo_count;

    logic              tvalid;
    logic              beat_last;
    logic [ADDR_W-1:0] beat_idx;
    logic [DATA_W-1:0] beat_data;

    assign abort_act = abort && (state_q != IDLE);

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + IFL_W'(vld_q[i]);
        end
    end

    // Every outstanding read owns a FIFO slot, so a returning word always has room.
    assign credit = (int'(in_flight) + int'(fifo_count)) < DEPTH;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && learn_done && !abort) begin
                    state_d = ISSUE;
                    accept  = 1'b1;
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue = 1'b1;
                    if (icnt_q == LAST_ISSUE) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (in_flight == '0 && fifo_empty) state_d = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_act) begin
            state_d = IDLE;
            issue   = 1'b0;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            icnt_q  <= '0;
            addr_q  <= FIRST_BIN;
        end else begin
            state_q <= state_d;
            if (accept) begin
                icnt_q <= '0;
                addr_q <= FIRST_BIN;
            end else if (issue) begin
                icnt_q <= icnt_q + ICNT_W'(1);
                if (addr_q != LAST_BIN) addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

    // Tag pipeline: the last stage lines up with rd_data for the same address.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) idx_q[i] <= '0;
        end else begin
            if (abort_act) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= issue;
                for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
            end
            idx_q[0] <= addr_q;
            for (int i = 1; i < RD_LAT; i++) idx_q[i] <= idx_q[i-1];
        end
    end

    assign rd_addr   = addr_q;
    assign fifo_push = vld_q[RD_LAT-1] && !abort_act;
    assign fifo_din  = {(idx_q[RD_LAT-1] == LAST_BIN), idx_q[RD_LAT-1], rd_data};
    assign fifo_pop  = tvalid && m_if.m_tready;

    spec_skid_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .flush (abort_act),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tvalid = !fifo_empty;
    assign {beat_last, beat_idx, beat_data} = fifo_dout;

    assign m_if.m_tvalid = tvalid;
    assign m_if.m_tdata  = tvalid ? beat_data : '0;
    assign m_if.m_tuser  = tvalid ? beat_idx  : '0;
    assign m_if.m_tlast  = tvalid && beat_last;

    assign busy = (state_q == ISSUE) || (state_q == DRAIN);
    assign done = (state_q == FIN) && !abort_act;

`ifdef SPEC_READER_PEAK_EN
    logic [DATA_W-1:0] max_val_q, peak_val_q;
    logic [ADDR_W-1:0] max_bin_q, peak_bin_q;

    // Strict compare keeps the earliest bin when values tie.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            max_val_q  <= '0;
            max_bin_q  <= '0;
            peak_val_q <= '0;
            peak_bin_q <= '0;
        end else begin
            if (accept) begin
                max_val_q <= '0;
                max_bin_q <= FIRST_BIN;
            end else if (fifo_pop && (beat_data > max_val_q)) begin
                max_val_q <= beat_data;
                max_bin_q <= beat_idx;
            end
            if (done) begin
                peak_val_q <= max_val_q;
                peak_bin_q <= max_bin_q;
            end
        end
    end

    assign peak_bin = peak_bin_q;
    assign peak_val = peak_val_q;
`else
    assign peak_bin = '0;
    assign peak_val = '0;
`endif

endmodule

// File: tb/tb_spec_reader.sv
// tb/tb_spec_reader.sv - directed self-checking bench for spec_reader
`timescale 1ns/1ps
module tb_spec_reader;

    localparam int AW = 12;
    localparam int DW = 24;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_50m = ~clk_50m;

    logic start = 1'b0, start1 = 1'b0, abort = 1'b0, learn_done = 1'b0;
    logic [AW-1:0] rd_addr, rd_addr1, peak_bin, peak_bin1;
    logic [DW-1:0] rd_data, rd_data1, peak_val, peak_val1;
    logic          busy, done, busy1, done1;

    spec_reader_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();
    spec_reader_if #(.ADDR_W(AW), .DATA_W(DW)) s1_if ();

    spec_reader #(.ADDR_W(AW), .DATA_W(DW), .BIN_START(0), .BIN_COUNT(8), .RD_LAT(2)) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .start(start), .abort(abort), .learn_done(learn_done),
        .rd_addr(rd_addr), .rd_data(rd_data), .m_if(s_if.master), .busy(busy), .done(done),
        .peak_bin(peak_bin), .peak_val(peak_val));

    spec_reader #(.ADDR_W(AW), .DATA_W(DW), .BIN_START(0), .BIN_COUNT(1), .RD_LAT(4)) dut1 (
        .clk_50m(clk_50m), .rst_n(rst_n), .start(start1), .abort(abort), .learn_done(learn_done),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .m_if(s1_if.master), .busy(busy1), .done(done1),
        .peak_bin(peak_bin1), .peak_val(peak_val1));

    // RAM models: latency 2 for dut, latency 4 for dut1
    logic [DW-1:0] ram [8];
    logic [DW-1:0] p0, p1;
    logic [DW-1:0] q0, q1, q2, q3;
    always @(posedge clk_50m) begin
        p0 <= ram[rd_addr[2:0]];
        p1 <= p0;
        q0 <= (rd_addr1 == '0) ? 24'd77 : 24'd999;
        q1 <= q0;
        q2 <= q1;
        q3 <= q2;
    end
    assign rd_data  = p1;
    assign rd_data1 = q3;
    assign s1_if.m_tready = 1'b1;

    logic       rdy_toggle = 1'b0;
    logic [3:0] rdy_pat = 4'b1001;
    int         ph = 0;
    always @(posedge clk_50m) begin
        #1;
        if (rdy_toggle) begin
            s_if.m_tready = rdy_pat[ph];
            ph = (ph + 1) % 4;
        end else begin
            s_if.m_tready = 1'b1;
        end
    end

    int n_checks = 0, n_errors = 0;
    int cyc = 0, n_done = 0, n_done1 = 0, stall_err = 0, n_stall = 0, addr_err = 0;
    int max_cnt = 0, busy_seen = 0, first_cyc = 0, last_cyc = 0;
    int n1 = 0, first1 = 0;
    logic [DW-1:0] d1;
    logic [AW-1:0] u1;
    logic          l1;
    logic [DW-1:0] bq_data [$];
    logic [AW-1:0] bq_user [$];
    logic          bq_last [$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] pd;
    logic [AW-1:0] pu;
    logic          pl;
    logic [DW-1:0] exp_d [8];

    always @(negedge clk_50m) begin
        cyc = cyc + 1;
        if (s_if.m_tvalid && s_if.m_tready) begin
            if (bq_data.size() == 0) first_cyc = cyc;
            last_cyc = cyc;
            bq_data.push_back(s_if.m_tdata);
            bq_user.push_back(s_if.m_tuser);
            bq_last.push_back(s_if.m_tlast);
        end
        if (prev_stall && (!s_if.m_tvalid || s_if.m_tdata != pd || s_if.m_tuser != pu || s_if.m_tlast != pl))
            stall_err = stall_err + 1;
        prev_stall = s_if.m_tvalid && !s_if.m_tready;
        if (prev_stall) n_stall = n_stall + 1;
        pd = s_if.m_tdata;
        pu = s_if.m_tuser;
        pl = s_if.m_tlast;
        if (done) n_done = n_done + 1;
        if (busy) busy_seen = busy_seen + 1;
        if (int'(dut.u_fifo.count_q) > max_cnt) max_cnt = int'(dut.u_fifo.count_q);
        if (rd_addr > 12'd7) addr_err = addr_err + 1;
        if (s1_if.m_tvalid && s1_if.m_tready) begin
            n1 = n1 + 1;
            if (n1 == 1) first1 = cyc;
            d1 = s1_if.m_tdata;
            u1 = s1_if.m_tuser;
            l1 = s1_if.m_tlast;
        end
        if (done1) n_done1 = n_done1 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic clear_mon();
        bq_data.delete();
        bq_user.delete();
        bq_last.delete();
        busy_seen = 0;
        stall_err = 0;
        n_stall   = 0;
        first_cyc = 0;
        last_cyc  = 0;
    endtask

    task automatic pulse_start(output int acc);
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input string tag, input int base);
        int i = 0;
        while (n_done == base && i < 300) begin
            tick();
            i++;
        end
        repeat (3) tick();
        chk({tag, "_done"}, 64'(n_done - base), 64'd1);
    endtask

    task automatic verify8(input string tag);
        chk({tag, "_nbeats"}, 64'(bq_data.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < bq_data.size()) begin
                chk($sformatf("%s_data%0d", tag, k), 64'(bq_data[k]), 64'(exp_d[k]));
                chk($sformatf("%s_user%0d", tag, k), 64'(bq_user[k]), 64'(k));
                chk($sformatf("%s_last%0d", tag, k), 64'(bq_last[k]), 64'(k == 7));
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1, d0, nb;
        for (int k = 0; k < 8; k++) begin
            ram[k]   = 24'(100 + k);
            exp_d[k] = 24'(100 + k);
        end

        // reset state
        repeat (3) tick();
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_tvalid", 64'(s_if.m_tvalid), 64'd0);
        chk("rst_tdata", 64'(s_if.m_tdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_peak_bin", 64'(peak_bin), 64'd0);
        chk("rst_peak_val", 64'(peak_val), 64'd0);
        rst_n = 1'b1;
        learn_done = 1'b1;
        repeat (2) tick();

        // 1: gapless sweep with ready held high
        clear_mon();
        d0 = n_done;
        pulse_start(acc);
        wait_done("t1", d0);
        verify8("t1");
        chk("t1_gapless", 64'(last_cyc - first_cyc), 64'd7);
        chk("t1_latency_ge3", 64'((first_cyc - acc - 1) >= 3), 64'd1);
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_addr_range", 64'(addr_err), 64'd0);
`ifdef SPEC_READER_PEAK_EN
        chk("t1_peak_bin", 64'(peak_bin), 64'd7);
        chk("t1_peak_val", 64'(peak_val), 64'd107);
`else
        chk("t1_peak_bin", 64'(peak_bin), 64'd0);
        chk("t1_peak_val", 64'(peak_val), 64'd0);
`endif

        // 2: ready toggling 1,0,0,1
        clear_mon();
        ph = 0;
        rdy_toggle = 1'b1;
        d0 = n_done;
        pulse_start(acc);
        wait_done("t2", d0);
        rdy_toggle = 1'b0;
        verify8("t2");
        chk("t2_stalls_seen", 64'(n_stall > 0), 64'd1);
        chk("t2_stall_stable", 64'(stall_err), 64'd0);
        chk("t2_fifo_bound", 64'(max_cnt <= 4), 64'd1);

        // 3: start without learn_done
        learn_done = 1'b0;
        clear_mon();
        d0 = n_done;
        pulse_start(acc);
        repeat (20) tick();
        chk("t3_busy", 64'(busy_seen), 64'd0);
        chk("t3_beats", 64'(bq_data.size()), 64'd0);
        chk("t3_done", 64'(n_done - d0), 64'd0);
        learn_done = 1'b1;

        // abort beats start in the same cycle
        clear_mon();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (10) tick();
        chk("abort_start_busy", 64'(busy_seen), 64'd0);
        chk("abort_start_beats", 64'(bq_data.size()), 64'd0);

        // 4: abort after three beats, then a fresh sweep
        clear_mon();
        d0 = n_done;
        pulse_start(acc);
        for (int i = 0; i < 100 && bq_data.size() < 3; i++) tick();
        chk("t4_three_beats", 64'(bq_data.size() >= 3), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        nb = bq_data.size();
        @(negedge clk_50m);
        chk("t4_tvalid_low", 64'(s_if.m_tvalid), 64'd0);
        chk("t4_busy_low", 64'(busy), 64'd0);
        repeat (20) tick();
        chk("t4_no_done", 64'(n_done - d0), 64'd0);
        chk("t4_no_more_beats", 64'(bq_data.size()), 64'(nb));
`ifdef SPEC_READER_PEAK_EN
        chk("t4_peak_hold", 64'(peak_bin), 64'd7);
`else
        chk("t4_peak_hold", 64'(peak_bin), 64'd0);
`endif
        clear_mon();
        d0 = n_done;
        pulse_start(acc);
        wait_done("t4r", d0);
        verify8("t4r");

        // 5: peak with a tie at bins 1 and 3
        ram[0] = 24'd5; ram[1] = 24'd9; ram[2] = 24'd3; ram[3] = 24'd9;
        ram[4] = 24'd1; ram[5] = 24'd0; ram[6] = 24'd2; ram[7] = 24'd4;
        for (int k = 0; k < 8; k++) exp_d[k] = ram[k];
        clear_mon();
        d0 = n_done;
        pulse_start(acc);
        wait_done("t5", d0);
        verify8("t5");
`ifdef SPEC_READER_PEAK_EN
        chk("t5_peak_bin", 64'(peak_bin), 64'd1);
        chk("t5_peak_val", 64'(peak_val), 64'd9);
`else
        chk("t5_peak_bin", 64'(peak_bin), 64'd0);
        chk("t5_peak_val", 64'(peak_val), 64'd0);
`endif

        // 6: single-bin sweep with read latency 4
        d0 = n_done1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        acc1 = cyc;
        for (int i = 0; i < 100 && n_done1 == d0; i++) tick();
        repeat (3) tick();
        chk("t6_done", 64'(n_done1 - d0), 64'd1);
        chk("t6_beats", 64'(n1), 64'd1);
        chk("t6_last", 64'(l1), 64'd1);
        chk("t6_data", 64'(d1), 64'd77);
        chk("t6_user", 64'(u1), 64'd0);
        chk("t6_latency_ge5", 64'((first1 - acc1 - 1) >= 5), 64'd1);
        chk("t6_busy_after", 64'(busy1), 64'd0);

        // async reset mid-sweep
        clear_mon();
        pulse_start(acc);
        repeat (4) tick();
        chk("ar_busy_before", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_tvalid", 64'(s_if.m_tvalid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_rd_addr", 64'(rd_addr), 64'd0);
        chk("ar_tdata", 64'(s_if.m_tdata), 64'd0);
        #2;
        rst_n = 1'b1;
        repeat (2) tick();
        clear_mon();
        d0 = n_done;
        pulse_start(acc);
        wait_done("ar_rerun", d0);
        verify8("ar_rerun");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spec_reader.md
Name: spec_reader

Overview:
- Reader end of the learned-spectrum modulus RAM.
- The learn controller writes modulus words (`data_modulus`/`modulus_addr`/`modulus_wren`) in the FFT clock domain. This block reads them back on the RAM's `clk_50m` read port.
- It streams bins in order to a downstream consumer (compare/equaliser/display) over a valid/ready stream, tolerating backpressure across the BRAM read latency.
- It optionally reports the peak bin of the sweep.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 24, modulus word width.
- BIN_START, 0, first bin address read.
- BIN_COUNT, 2048, number of bins per sweep (1..2^ADDR_W−BIN_START).
- RD_LAT, 2, RAM `doutb` latency in clocks (1..4).

Ports:
- `clk_50m` in 1: sole clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request to begin a sweep.
- `abort` in 1: synchronous cancel of the current sweep.
- `learn_done` in 1: level; high when RAM contents are valid.
- `rd_addr` out ADDR_W: RAM read address (port B).
- `rd_data` in DATA_W: RAM read data, valid RD_LAT clocks after `rd_addr`.
- `m_tdata` out DATA_W: modulus of the current bin.
- `m_tuser` out ADDR_W: bin index of `m_tdata`.
- `m_tvalid` out 1: stream valid.
- `m_tready` in 1: stream ready.
- `m_tlast` out 1: marks the final bin of the sweep.
- `busy` out 1: high from accepted start until done.
- `done` out 1: one-cycle pulse at sweep end.
- `peak_bin` out ADDR_W: index of the largest modulus of the last sweep.
- `peak_val` out DATA_W: largest modulus of the last sweep.

Behaviour:
- Reset values: all outputs 0; `rd_addr` = BIN_START; FSM in IDLE; FIFO empty.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: `start` && `learn_done` → ISSUE with issue counter = 0. `start` without `learn_done` is ignored. `start` while not IDLE is ignored.
  - ISSUE: one read issued per clock while credit is available. Credit condition: in_flight + fifo_count < RD_LAT+2.
    - Issued address = BIN_START + issue counter.
    - After issuing BIN_COUNT reads → DRAIN.
  - DRAIN: wait until in_flight = 0 and FIFO empty (last beat accepted) → FIN.
  - FIN: `done` = 1 for one clock, `busy` = 0, peak outputs updated → IDLE.
- Read pipeline:
  - A RD_LAT-deep valid/index shift register tracks in-flight reads.
  - Returning `rd_data` plus its index is pushed into a FIFO of depth RD_LAT+2.
  - The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure.
- Stream:
  - `m_tdata`/`m_tuser`/`m_tlast` come from the FIFO head; `m_tvalid` = FIFO not empty.
  - A beat transfers on `m_tvalid` && `m_tready`.
  - While `m_tvalid` is high and `m_tready` is low, outputs hold stable.
  - `m_tlast` = 1 exactly on the beat with index BIN_START+BIN_COUNT−1.
  - First beat appears no earlier than RD_LAT+1 clocks after start acceptance.
  - With `m_tready` held high, the stream is gapless: one beat per clock.
- Boundaries:
  - BIN_COUNT = 1: a single beat carries `m_tlast`.
  - The address never wraps past BIN_START+BIN_COUNT−1.
  - `abort` (any state except IDLE):
    - flush FIFO and in-flight tracker; `m_tvalid` = 0 next clock;
    - no `done` pulse; peak outputs unchanged; → IDLE.
  - `abort` and `start` in the same cycle: `abort` wins.
  - `learn_done` falling mid-sweep: ignored; the sweep completes.
  - Async reset mid-sweep: all state returns to reset values immediately.

Optional Feature:
- Macro: SPEC_READER_PEAK_EN.
- Defined:
  - a running max over transferred beats, compared strictly greater, so the lowest bin wins ties;
  - the running max clears at start acceptance;
  - `peak_bin`/`peak_val` are registered in FIN and hold until the next completed sweep.
- Undefined: `peak_bin` and `peak_val` are tied to 0; no comparator logic.

Decomposition:
- Shared package `spec_pkg`: FSM state enum (IDLE/ISSUE/DRAIN/FIN), default ADDR_W/DATA_W/BIN_COUNT constants shared with the learn controller.
- One natural sub-module: `spec_skid_fifo`, a parameterised synchronous FIFO (width DATA_W+ADDR_W+1, depth RD_LAT+2) with count output.

Test Plan:
1. BIN_COUNT=8, RAM bin k = 100+k, `m_tready`=1, `start` with `learn_done`=1:
   - 8 consecutive beats, tdata 100..107, tuser 0..7;
   - tlast on beat 8; one `done` pulse; `busy` low afterwards.
2. Same setup with `m_tready` toggling 1,0,0,1 repeatedly:
   - identical data order, no loss or duplication;
   - outputs stable while stalled; FIFO count never exceeds RD_LAT+2.
3. `start` with `learn_done`=0: no read issued, `busy` stays 0, no beats, no `done`.
4. `abort` asserted after 3 beats:
   - `m_tvalid`=0 next clock, no `done`;
   - a fresh `start` then yields the full 8-beat sweep beginning at bin 0.
5. PEAK_EN defined, data {5,9,3,9,1,0,2,4}: `peak_bin`=1, `peak_val`=9 after `done`. Undefined: both 0.
6. BIN_COUNT=1, RD_LAT=4: a single beat with tlast=1, first beat ≥5 clocks after start; `done` follows.
